tail_lamp_ctrl_n: RTL

//  Parametrised rear-lamp controller: LAMPS lamps per side, sweep speed set by an internal prescaler.

---
 rtl/tail_lamp_pkg.sv | 34 +++
 rtl/lamp_tick_gen.sv | 38 +++
 rtl/tail_lamp_ctrl_n.sv | 139 +++++++++++++
 3 files changed

// File: rtl/tail_lamp_pkg.sv
// Shared types and helpers for the rear-lamp controller.
package tail_lamp_pkg;

   // Widest lamp bank the sweep helper can describe.
   localparam int unsigned MAX_LAMPS = 32;

   // Driver-visible modes occupy 0..7; MODE_TEST is internal only and is
   // reported to the driver stage as BRAKE (all lamps on).
   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      LEFT      = 4'd1,
      RIGHT     = 4'd2,
      BRAKE     = 4'd3,
      BRAKE_L   = 4'd4,
      BRAKE_R   = 4'd5,
      HAZARD    = 4'd6,
      FAULT     = 4'd7,
      MODE_TEST = 4'd8
   } mode_t;

   // Sweep frame: step 0 dark, step k lights bits k-1 and k-2 when in range.
   function automatic logic [MAX_LAMPS-1:0] sweep_pattern(input int unsigned step,
                                                          input int unsigned lamps);
      logic [MAX_LAMPS-1:0] pat;
      pat = '0;
      for (int unsigned i = 0; i < MAX_LAMPS; i++) begin
         if (i < lamps && step >= 1 && (i + 1 == step || i + 2 == step)) begin
            pat[i] = 1'b1;
         end
      end
      return pat;
   endfunction

endpackage

// File: rtl/lamp_tick_gen.sv
// Animation prescaler: one-cycle tick every TICK_DIV clocks, restartable.
module lamp_tick_gen #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Tick fires on the last count of each period.
   always_comb begin
      tick = (cnt_q == CntLast);
   end

   // Next count: restart and wrap both return to zero.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart || tick) begin
         cnt_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tail_lamp_ctrl_n.sv
// Rear-lamp controller: turn sweeps, brake combinations, hazard, sticky fault and lamp test.
module tail_lamp_ctrl_n
   import tail_lamp_pkg::*;
#(
   parameter int unsigned LAMPS    = 3,
   parameter int unsigned TICK_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             turn_left,
   input  logic             turn_right,
   input  logic             brake,
   input  logic             fault,
   input  logic             fault_clr,
   input  logic             lamp_test,
   output logic [LAMPS-1:0] left_lamp,
   output logic [LAMPS-1:0] right_lamp,
   output logic [2:0]       mode_o,
   output logic             fault_sticky
);

   localparam int unsigned StepW = $clog2(LAMPS + 2);
   localparam logic [StepW-1:0] StepLast = StepW'(LAMPS + 1);

   mode_t            mode_q, mode_d;
   logic [StepW-1:0] step_q, step_d;
   logic             blink_q, blink_d;
   logic             sticky_q, sticky_d;
   logic             mode_chg;
   logic             tick;
   logic             sweeping;
   logic             flashing;
   logic [LAMPS-1:0] sweep;
   logic [LAMPS-1:0] sweep_rev;

   lamp_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (mode_chg),
      .tick    (tick)
   );

   // State register for mode, sweep step, flash phase and sticky fault.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q   <= IDLE;
         step_q   <= '0;
         blink_q  <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         step_q   <= step_d;
         blink_q  <= blink_d;
         sticky_q <= sticky_d;
      end
   end

   // Next-state: sticky fault, prioritised mode, sweep step and blink phase.
   always_comb begin
      sticky_d = sticky_q;
      if (fault) begin
         sticky_d = 1'b1;
      end else if (fault_clr) begin
         sticky_d = 1'b0;
      end

      // Using sticky_d lets a clear drop out of FAULT on the same edge.
      if (sticky_d)                          mode_d = FAULT;
      else if (lamp_test)                    mode_d = MODE_TEST;
      else if (brake && turn_left && turn_right) mode_d = BRAKE;
      else if (brake && turn_left)           mode_d = BRAKE_L;
      else if (brake && turn_right)          mode_d = BRAKE_R;
      else if (brake)                        mode_d = BRAKE;
      else if (turn_left && turn_right)      mode_d = HAZARD;
      else if (turn_left)                    mode_d = LEFT;
      else if (turn_right)                   mode_d = RIGHT;
      else                                   mode_d = IDLE;

      mode_chg = (mode_d != mode_q);
      sweeping = (mode_q == LEFT) || (mode_q == RIGHT) ||
                 (mode_q == BRAKE_L) || (mode_q == BRAKE_R);
      flashing = (mode_q == HAZARD) || (mode_q == FAULT);

      step_d  = '0;
      blink_d = 1'b0;
      if (mode_chg) begin
         blink_d = (mode_d == HAZARD) || (mode_d == FAULT);
      end else begin
         if (sweeping) begin
            step_d = step_q;
            if (tick) begin
               step_d = (step_q == StepLast) ? '0 : step_q + 1'b1;
            end
         end
         if (flashing) begin
            blink_d = tick ? ~blink_q : blink_q;
         end
      end
   end

   // Output decode from registered mode, step and blink phase.
   always_comb begin
      sweep = LAMPS'(sweep_pattern(int'(step_q), LAMPS));
      for (int i = 0; i < int'(LAMPS); i++) begin
         sweep_rev[i] = sweep[int'(LAMPS) - 1 - i];
      end

      left_lamp  = '0;
      right_lamp = '0;
      unique case (mode_q)
         IDLE: ;
         LEFT:      left_lamp = sweep;
         RIGHT:     right_lamp = sweep_rev;
         BRAKE, MODE_TEST: begin
            left_lamp  = '1;
            right_lamp = '1;
         end
         BRAKE_L: begin
            left_lamp  = sweep;
            right_lamp = '1;
         end
         BRAKE_R: begin
            left_lamp  = '1;
            right_lamp = sweep_rev;
         end
         HAZARD, FAULT: begin
            left_lamp  = {LAMPS{blink_q}};
            right_lamp = {LAMPS{blink_q}};
         end
         default: ;
      endcase

      mode_o       = (mode_q == MODE_TEST) ? 3'(BRAKE) : mode_q[2:0];
      fault_sticky = sticky_q;
   end

endmodule
